// File: rtl/dac_feeder_if.sv
// FIFO-side and DAC-side signal bundle for dac_feeder.
// master: the feeder itself; slave: the FIFO/DAC/control environment around it.
interface dac_feeder_if #(
    parameter int DATA_W = 12
);
    logic              enable_i;
    logic              empty_i;
    logic [DATA_W-1:0] rdata_i;
    logic              clr_i;
    logic              rden_o;
    logic [DATA_W-1:0] dac_data_o;
    logic              dac_wr_o;
    logic              underrun_o;
    logic [15:0]       underrun_cnt_o;

    modport master (
        input  enable_i,
        input  empty_i,
        input  rdata_i,
        input  clr_i,
        output rden_o,
        output dac_data_o,
        output dac_wr_o,
        output underrun_o,
        output underrun_cnt_o
    );

    modport slave (
        output enable_i,
        output empty_i,
        output rdata_i,
        output clr_i,
        input  rden_o,
        input  dac_data_o,
        input  dac_wr_o,
        input  underrun_o,
        input  underrun_cnt_o
    );
endinterface

// File: rtl/dac_feeder.sv
// Paces FIFO pops at one sample per DIV clocks and presents each word to a parallel DAC.
// Optional macro DAC_FEEDER_MIDSCALE_EN: reset/underrun code becomes midscale instead of 0/hold.
module dac_feeder #(
    parameter int DATA_W = 12,
    parameter int DIV    = 20
) (
    input  logic         clk,
    input  logic         rst,
    dac_feeder_if.master bus
);

    localparam logic [7:0] CNT_RELOAD = 8'(DIV - 1);
`ifdef DAC_FEEDER_MIDSCALE_EN
    localparam logic [DATA_W-1:0] MID_CODE  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] IDLE_CODE = MID_CODE;
`else
    localparam logic [DATA_W-1:0] IDLE_CODE = {DATA_W{1'b0}};
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_POP    = 3'd2,
        S_LATCH  = 3'd3,
        S_STROBE = 3'd4
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_rden;
    logic              r_dac_wr;
    logic [DATA_W-1:0] r_dac_data;
    logic              r_uflow_pend;
    logic              r_underrun;
    logic [15:0]       r_underrun_cnt;

    logic w_tick;
    logic w_serve;
    logic w_underrun;

    // STROBE also services a tick so that the shortest period (DIV=3) never misses one
    assign w_tick     = (r_state != S_IDLE) && bus.enable_i && (r_cnt == 8'd0);
    assign w_serve    = w_tick && ((r_state == S_WAIT) || (r_state == S_STROBE));
    assign w_underrun = w_serve && bus.empty_i;

    // Pace counter: free-runs DIV-1..0 while enabled, parked at DIV-1 otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_RELOAD;
        end else if ((r_state == S_IDLE) || !bus.enable_i) begin
            r_cnt <= CNT_RELOAD;
        end else if (r_cnt == 8'd0) begin
            r_cnt <= CNT_RELOAD;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Sample FSM: pop, latch, strobe; a popped word always completes even if enable drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rden       <= 1'b0;
            r_dac_wr     <= 1'b0;
            r_dac_data   <= IDLE_CODE;
            r_uflow_pend <= 1'b0;
        end else begin
            r_rden   <= 1'b0;
            r_dac_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable_i) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!bus.enable_i) begin
                        r_state <= S_IDLE;
                    end else if (w_serve) begin
                        r_state      <= S_POP;
                        r_rden       <= !bus.empty_i;
                        r_uflow_pend <= bus.empty_i;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_POP: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_state <= S_STROBE;
                    if (r_uflow_pend) begin
`ifdef DAC_FEEDER_MIDSCALE_EN
                        r_dac_data <= MID_CODE;
`else
                        r_dac_data <= r_dac_data;
`endif
                    end else begin
                        r_dac_data <= bus.rdata_i;
                    end
                end
                S_STROBE: begin
                    r_dac_wr <= 1'b1;
                    if (!bus.enable_i) begin
                        r_state <= S_IDLE;
                    end else if (w_serve) begin
                        r_state      <= S_POP;
                        r_rden       <= !bus.empty_i;
                        r_uflow_pend <= bus.empty_i;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky underrun flag and saturating count; an underrun wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else if (w_underrun) begin
            r_underrun <= 1'b1;
            if (bus.clr_i) begin
                r_underrun_cnt <= 16'd1;
            end else if (r_underrun_cnt != 16'hFFFF) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end else begin
                r_underrun_cnt <= r_underrun_cnt;
            end
        end else if (bus.clr_i) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else begin
            r_underrun     <= r_underrun;
            r_underrun_cnt <= r_underrun_cnt;
        end
    end

    assign bus.rden_o         = r_rden;
    assign bus.dac_wr_o       = r_dac_wr;
    assign bus.dac_data_o     = r_dac_data;
    assign bus.underrun_o     = r_underrun;
    assign bus.underrun_cnt_o = r_underrun_cnt;

endmodule

// File: tb/tb_dac_feeder.sv
// Self-checking bench for dac_feeder: directed scenario table, corner-case sequences,
// and randomized FIFO traffic against a period-level reference model.
module tb_dac_feeder;

    localparam int DW  = 12;
    localparam int DIV = 20;
`ifdef DAC_FEEDER_MIDSCALE_EN
    localparam logic [DW-1:0] IDLE_CODE = 12'h800;
`else
    localparam logic [DW-1:0] IDLE_CODE = 12'h000;
`endif

    typedef struct {
        int            cyc;
        logic          rden;
        logic          wr;
        logic [DW-1:0] data;
        logic          uf;
        logic [15:0]   cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    logic [DW-1:0] q[$];

    dac_feeder_if #(.DATA_W(DW)) bus ();

    dac_feeder #(.DATA_W(DW), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // FIFO read port: data appears the cycle after a sampled pop strobe
    always @(posedge clk) begin
        if (bus.rden_o && (q.size() > 0)) begin
            bus.rdata_i <= q.pop_front();
        end
    end

    function automatic logic [DW-1:0] underrun_word(input logic [DW-1:0] held);
`ifdef DAC_FEEDER_MIDSCALE_EN
        return 12'h800;
`else
        return held;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
        bus.empty_i = (q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
        bus.empty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.enable_i = 1'b0;
        bus.clr_i    = 1'b0;
        q.delete();
        bus.empty_i  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string name, input int c, input logic e_rden, input logic e_wr,
                         input logic [DW-1:0] e_data, input logic e_uf, input logic [15:0] e_cnt);
        vectors++;
        if ((bus.rden_o !== e_rden) || (bus.dac_wr_o !== e_wr) || (bus.dac_data_o !== e_data) ||
            (bus.underrun_o !== e_uf) || (bus.underrun_cnt_o !== e_cnt)) begin
            errors++;
            $display("FAIL %s cyc=%0d got rden=%b wr=%b data=%h uf=%b cnt=%h want rden=%b wr=%b data=%h uf=%b cnt=%h",
                     name, c, bus.rden_o, bus.dac_wr_o, bus.dac_data_o, bus.underrun_o, bus.underrun_cnt_o,
                     e_rden, e_wr, e_data, e_uf, e_cnt);
        end
    endtask

    initial begin
        vec_t          tbl[14];
        int            idx;
        logic [DW-1:0] ua;
        logic [DW-1:0] mq[$];
        logic [DW-1:0] exp_data, pend, w;
        logic          e_rden, e_uf;
        logic [15:0]   e_cnt;
        int            data_due, wr_due;

        bus.enable_i = 1'b0;
        bus.empty_i  = 1'b1;
        bus.clr_i    = 1'b0;

        // ---- directed table: two pops, then an underrun period ----
        ua = underrun_word(12'h456);
        tbl[0]  = '{0,  1'b0, 1'b0, IDLE_CODE, 1'b0, 16'd0};
        tbl[1]  = '{19, 1'b0, 1'b0, IDLE_CODE, 1'b0, 16'd0};
        tbl[2]  = '{20, 1'b1, 1'b0, IDLE_CODE, 1'b0, 16'd0};
        tbl[3]  = '{21, 1'b0, 1'b0, IDLE_CODE, 1'b0, 16'd0};
        tbl[4]  = '{22, 1'b0, 1'b0, 12'h123,   1'b0, 16'd0};
        tbl[5]  = '{23, 1'b0, 1'b1, 12'h123,   1'b0, 16'd0};
        tbl[6]  = '{24, 1'b0, 1'b0, 12'h123,   1'b0, 16'd0};
        tbl[7]  = '{40, 1'b1, 1'b0, 12'h123,   1'b0, 16'd0};
        tbl[8]  = '{42, 1'b0, 1'b0, 12'h456,   1'b0, 16'd0};
        tbl[9]  = '{43, 1'b0, 1'b1, 12'h456,   1'b0, 16'd0};
        tbl[10] = '{59, 1'b0, 1'b0, 12'h456,   1'b0, 16'd0};
        tbl[11] = '{60, 1'b0, 1'b0, 12'h456,   1'b1, 16'd1};
        tbl[12] = '{62, 1'b0, 1'b0, ua,        1'b1, 16'd1};
        tbl[13] = '{63, 1'b0, 1'b1, ua,        1'b1, 16'd1};

        do_reset();
        check("reset", -1, 1'b0, 1'b0, IDLE_CODE, 1'b0, 16'd0);
        push(12'h123);
        push(12'h456);
        bus.enable_i = 1'b1;
        idx = 0;
        for (int c = 0; c <= 64; c++) begin
            step();
            if ((idx < 14) && (tbl[idx].cyc == c)) begin
                check("table", c, tbl[idx].rden, tbl[idx].wr, tbl[idx].data, tbl[idx].uf, tbl[idx].cnt);
                idx++;
            end
        end

        // ---- enable dropped the cycle after the pop ----
        do_reset();
        push(12'h3C5);
        push(12'h5A7);
        bus.enable_i = 1'b1;
        for (int c = 0; c <= 80; c++) begin
            step();
            check("en_drop", c, c == 20, c == 23, (c >= 22) ? 12'h3C5 : IDLE_CODE, 1'b0, 16'd0);
            if (c == 21) bus.enable_i = 1'b0;
        end
        vectors++;
        if (q.size() != 1) begin
            errors++;
            $display("FAIL en_drop_fifo_left got %0d words want 1", q.size());
        end

        // ---- saturation, then clear colliding with an underrun, then plain clear ----
        do_reset();
        bus.enable_i = 1'b1;
        for (int c = 0; c <= 90; c++) begin
            step();
            e_uf  = (c >= 20) && (c < 86);
            e_cnt = (c <= 5) ? 16'd0 : (c < 20) ? 16'hFFFE : (c < 80) ? 16'hFFFF : (c < 86) ? 16'd1 : 16'd0;
            check("saturate_clr", c, 1'b0, (c == 23) || (c == 43) || (c == 63) || (c == 83),
                  IDLE_CODE, e_uf, e_cnt);
            if (c == 5) begin
                force dut.r_underrun_cnt = 16'hFFFE;
                #1;
                release dut.r_underrun_cnt;
            end
            if ((c == 79) || (c == 85)) bus.clr_i = 1'b1;
            if ((c == 80) || (c == 86)) bus.clr_i = 1'b0;
        end

        // ---- reset asserted while in POP ----
        do_reset();
        push(12'h2B9);
        push(12'h6D1);
        bus.enable_i = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            step();
            check("pre_rst", c, c == 20, 1'b0, IDLE_CODE, 1'b0, 16'd0);
        end
        #2 rst = 1'b1;
        #1 check("rst_async", 20, 1'b0, 1'b0, IDLE_CODE, 1'b0, 16'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_hold", c, 1'b0, 1'b0, IDLE_CODE, 1'b0, 16'd0);
        end
        rst = 1'b0;
        for (int c = 0; c <= 25; c++) begin
            step();
            check("post_rst", c, c == 20, c == 23, (c >= 22) ? 12'h2B9 : IDLE_CODE, 1'b0, 16'd0);
        end

        // ---- randomized FIFO traffic vs. per-period reference ----
        do_reset();
        mq.delete();
        for (int i = 0; i < 3; i++) begin
            w = 12'($urandom_range(0, 4095));
            push(w);
            mq.push_back(w);
        end
        bus.enable_i = 1'b1;
        exp_data = IDLE_CODE;
        pend     = IDLE_CODE;
        e_uf     = 1'b0;
        e_cnt    = 16'd0;
        data_due = -1;
        wr_due   = -1;
        for (int c = 0; c < 40 * DIV; c++) begin
            step();
            e_rden = 1'b0;
            if (c == data_due) exp_data = pend;
            if ((c > 0) && (c % DIV == 0)) begin
                if (mq.size() > 0) begin
                    e_rden = 1'b1;
                    pend   = mq.pop_front();
                end else begin
                    e_uf = 1'b1;
                    if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
                    pend = underrun_word(exp_data);
                end
                data_due = c + 2;
                wr_due   = c + 3;
            end
            check("random", c, e_rden, c == wr_due, exp_data, e_uf, e_cnt);
            if ($urandom_range(0, 99) < 5) begin
                w = 12'($urandom_range(0, 4095));
                push(w);
                mq.push_back(w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
